// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared state type, defaults and sizing helpers for the SAR scan controller
package adc_sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_ACC,
    ST_OUT
  } state_t;

  localparam int OSR_MAX_DEF = 3;

  // Number of conversions averaged for oversampling exponent m (4^m)
  function automatic int osr_limit(input int m);
    return 1 << (2 * m);
  endfunction

  // Select width that never collapses to zero bits for a single channel
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_osr_accum.sv
// adc_osr_accum: sums 4^m conversion codes and produces the decimated, right-aligned result
module adc_osr_accum
  import adc_sar_pkg::*;
#(
  parameter int RES_W   = 12,
  parameter int OSR_MAX = OSR_MAX_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_add,
  input  logic [RES_W-1:0]         i_code,
  input  logic [2:0]               i_m,
  output logic                     o_done,
  output logic [RES_W+OSR_MAX-1:0] o_result
);

  localparam int ACC_W = RES_W + 2 * OSR_MAX;
  localparam int CNT_W = 2 * OSR_MAX + 1;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Running sum including the code being added; done when this is the 4^m-th sample
  always_comb begin
    w_sum     = r_acc + ACC_W'(i_code);
    w_cnt_nxt = r_cnt + CNT_W'(1);
    o_done    = w_cnt_nxt == CNT_W'(osr_limit(int'(i_m)));
    w_shift   = w_sum >> i_m;
    o_result  = w_shift[RES_W+OSR_MAX-1:0];
  end

  // Accumulate each conversion; clear once a full oversampling set is complete
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_acc <= o_done ? '0 : w_sum;
      r_cnt <= o_done ? '0 : w_cnt_nxt;
    end
  end

endmodule

// File: rtl/adc_sar_scan_ctrl.sv
// adc_sar_scan_ctrl: multi-channel oversampling SAR sequencer with valid/ready result output
module adc_sar_scan_ctrl
  import adc_sar_pkg::*;
#(
  parameter int RES_W      = 12,
  parameter int CHANNELS   = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int OSR_MAX    = OSR_MAX_DEF
) (
  input  logic                          clk_dig_in,
  input  logic                          rst_n,
  input  logic                          start_in,
  input  logic                          continuous_in,
  input  logic [CHANNELS-1:0]           ch_mask_in,
  input  logic [2:0]                    osr_mode_in,
  input  logic                          comparator_in,
  output logic                          sample_out,
  output logic                          sample_out_n,
  output logic                          enable_loop_out,
  output logic [sel_w(CHANNELS)-1:0]    ch_sel_out,
  output logic [RES_W-1:0]              dac_p_out,
  output logic [RES_W-1:0]              dac_n_out,
  output logic                          result_valid_out,
  input  logic                          result_ready_in,
  output logic [RES_W+OSR_MAX-1:0]      result_data_out,
  output logic [sel_w(CHANNELS)-1:0]    result_ch_out,
  output logic                          busy_out,
  output logic                          scan_done_out
);

  localparam int SEL_W = sel_w(CHANNELS);
  localparam int CNT_W = $clog2(((SAMPLE_CYC > RES_W) ? SAMPLE_CYC : RES_W) + 1);
  localparam logic [RES_W-1:0] MSB = RES_W'(1) << (RES_W - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [RES_W-1:0]         r_code;
  logic [RES_W-1:0]         w_trial;
  logic [SEL_W-1:0]         r_ch;
  logic [SEL_W-1:0]         w_first_ch;
  logic [SEL_W-1:0]         w_next_ch;
  logic                     w_has_next;
  logic [CHANNELS-1:0]      r_mask;
  logic [2:0]               r_m;
  logic [2:0]               w_m_clamp;
  logic                     w_restart;
  logic                     w_latch;
  logic                     w_advance;
  logic                     w_osr_done;
  logic [RES_W+OSR_MAX-1:0] w_result;
  logic [RES_W+OSR_MAX-1:0] r_res_data;
  logic [SEL_W-1:0]         r_res_ch;
  logic                     r_done;

  adc_osr_accum #(
    .RES_W   (RES_W),
    .OSR_MAX (OSR_MAX)
  ) u_accum (
    .i_clk    (clk_dig_in),
    .i_rst_n  (rst_n),
    .i_add    (r_state == ST_ACC),
    .i_code   (r_code),
    .i_m      (r_m),
    .o_done   (w_osr_done),
    .o_result (w_result)
  );

  // Channel scan helpers: lowest channel of the incoming mask, next higher one of the latched mask
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = r_ch;
    w_has_next = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_mask_in[i]) w_first_ch = SEL_W'(i);
      if (r_mask[i] && i > int'(r_ch)) begin
        w_next_ch  = SEL_W'(i);
        w_has_next = 1'b1;
      end
    end
    w_m_clamp = (osr_mode_in > 3'(OSR_MAX)) ? 3'(OSR_MAX) : osr_mode_in;
    w_restart = continuous_in && |ch_mask_in;
    w_trial   = r_code | (MSB >> r_cnt);
    w_latch   = (r_state == ST_IDLE && w_next == ST_SAMPLE) ||
                (r_state == ST_OUT && result_ready_in && !w_has_next && w_restart);
    w_advance = r_state == ST_OUT && result_ready_in && w_has_next;
  end

  // State register
  always_ff @(posedge clk_dig_in) begin
    r_state <= !rst_n ? ST_IDLE : w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = (start_in && |ch_mask_in) ? ST_SAMPLE : ST_IDLE;
      ST_SAMPLE: w_next = (r_cnt == CNT_W'(SAMPLE_CYC - 1)) ? ST_CONV : ST_SAMPLE;
      ST_CONV:   w_next = (r_cnt == CNT_W'(RES_W - 1)) ? ST_ACC : ST_CONV;
      ST_ACC:    w_next = w_osr_done ? ST_OUT : ST_SAMPLE;
      ST_OUT:    w_next = !result_ready_in ? ST_OUT :
                          (w_has_next || w_restart) ? ST_SAMPLE : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode: Moore outputs so ready never reaches valid combinationally
  always_comb begin
    sample_out       = r_state == ST_SAMPLE;
    sample_out_n     = !sample_out;
    enable_loop_out  = r_state == ST_CONV;
    busy_out         = r_state != ST_IDLE;
    result_valid_out = r_state == ST_OUT;
    dac_p_out        = enable_loop_out ? w_trial : '0;
    dac_n_out        = busy_out ? ~dac_p_out : '0;
    ch_sel_out       = r_ch;
    result_data_out  = r_res_data;
    result_ch_out    = r_res_ch;
    scan_done_out    = r_done;
  end

  // Phase counter and SAR register: cleared while sampling, one decision per CONV cycle
  always_ff @(posedge clk_dig_in) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_code <= '0;
    end else begin
      r_cnt  <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_code <= (r_state == ST_CONV) ? (comparator_in ? w_trial : r_code) :
                (r_state == ST_SAMPLE) ? '0 : r_code;
    end
  end

  // Scan configuration latch and channel advance
  always_ff @(posedge clk_dig_in) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_m    <= '0;
      r_ch   <= '0;
    end else if (w_latch) begin
      r_mask <= ch_mask_in;
      r_m    <= w_m_clamp;
      r_ch   <= w_first_ch;
    end else if (w_advance) begin
      r_ch <= w_next_ch;
    end
  end

  // Result capture and end-of-scan pulse
  always_ff @(posedge clk_dig_in) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_ch   <= '0;
      r_done     <= 1'b0;
    end else begin
      if (r_state == ST_ACC && w_osr_done) begin
        r_res_data <= w_result;
        r_res_ch   <= r_ch;
      end
      r_done <= r_state == ST_OUT && result_ready_in && w_next == ST_IDLE;
    end
  end

endmodule

// File: tb/tb_adc_sar_scan_ctrl.sv
// tb_adc_sar_scan_ctrl: directed table-driven bench for the SAR scan controller
module tb_adc_sar_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic        continuous_in;
  logic [3:0]  ch_mask_in;
  logic [2:0]  osr_mode_in;
  logic        comparator_in;
  logic        sample_out;
  logic        sample_out_n;
  logic        enable_loop_out;
  logic [1:0]  ch_sel_out;
  logic [11:0] dac_p_out;
  logic [11:0] dac_n_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic [14:0] result_data_out;
  logic [1:0]  result_ch_out;
  logic        busy_out;
  logic        scan_done_out;

  logic [11:0] vin [4];
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [2:0]  osr;
    int          lat;
    int          n;
    logic [1:0]  ch0;
    logic [14:0] d0;
    logic [1:0]  chl;
    logic [14:0] dl;
  } vec_t;

  vec_t vecs [7];

  adc_sar_scan_ctrl dut (
    .clk_dig_in       (clk),
    .rst_n            (rst_n),
    .start_in         (start_in),
    .continuous_in    (continuous_in),
    .ch_mask_in       (ch_mask_in),
    .osr_mode_in      (osr_mode_in),
    .comparator_in    (comparator_in),
    .sample_out       (sample_out),
    .sample_out_n     (sample_out_n),
    .enable_loop_out  (enable_loop_out),
    .ch_sel_out       (ch_sel_out),
    .dac_p_out        (dac_p_out),
    .dac_n_out        (dac_n_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_data_out  (result_data_out),
    .result_ch_out    (result_ch_out),
    .busy_out         (busy_out),
    .scan_done_out    (scan_done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator: keep the trial bit while the trial code does not exceed the input
  assign comparator_in = dac_p_out <= vin[ch_sel_out];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!result_valid_out && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    result_ready_in = 1'b1;
    @(posedge clk); #1;
    result_ready_in = 1'b0;
  endtask

  task automatic kick(input logic [3:0] mask, input logic [2:0] osr);
    @(negedge clk);
    ch_mask_in  = mask;
    osr_mode_in = osr;
    start_in    = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int lat;
    int w;
    int n;
    logic [1:0]  ch0, chl;
    logic [14:0] d0, dl;
    ch0 = '0; chl = '0; d0 = '0; dl = '0;
    kick(v.mask, v.osr);
    check({tag, "_sample_at_start"}, 32'(sample_out), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, lat, v.lat);
    n = 0;
    while (n < 8) begin
      wait_valid(w);
      if (n == 0) begin
        ch0 = result_ch_out;
        d0  = result_data_out;
      end
      chl = result_ch_out;
      dl  = result_data_out;
      handshake();
      n++;
      if (scan_done_out || !busy_out) break;
    end
    check({tag, "_count"}, n, v.n);
    check({tag, "_first_ch"}, 32'(ch0), 32'(v.ch0));
    check({tag, "_first_data"}, 32'(d0), 32'(v.d0));
    check({tag, "_last_ch"}, 32'(chl), 32'(v.chl));
    check({tag, "_last_data"}, 32'(dl), 32'(v.dl));
    check({tag, "_done_pulse"}, 32'({scan_done_out, busy_out}), 32'b10);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(scan_done_out), 32'd0);
  endtask

  initial begin
    logic        bad;
    logic [14:0] hd;
    logic [1:0]  hc;
    logic [1:0]  chs [4];
    logic        mid_done;
    int          w;

    vin[0] = 12'hA5C;
    vin[1] = 12'h100;
    vin[2] = 12'hFFF;
    vin[3] = 12'h000;
    //          mask     osr   lat  n  ch0   d0        chl   dl
    vecs[0] = '{4'b0001, 3'd0, 15,  1, 2'd0, 15'hA5C,  2'd0, 15'hA5C};
    vecs[1] = '{4'b0010, 3'd1, 60,  1, 2'd1, 15'h200,  2'd1, 15'h200};
    vecs[2] = '{4'b1010, 3'd0, 15,  2, 2'd1, 15'h100,  2'd3, 15'h000};
    vecs[3] = '{4'b0100, 3'd2, 240, 1, 2'd2, 15'h3FFC, 2'd2, 15'h3FFC};
    vecs[4] = '{4'b1111, 3'd0, 15,  4, 2'd0, 15'hA5C,  2'd3, 15'h000};
    vecs[5] = '{4'b0100, 3'd7, 960, 1, 2'd2, 15'h7FF8, 2'd2, 15'h7FF8};
    vecs[6] = '{4'b0001, 3'd3, 960, 1, 2'd0, 15'h52E0, 2'd0, 15'h52E0};

    rst_n = 1'b0;
    start_in = 1'b0;
    continuous_in = 1'b0;
    ch_mask_in = '0;
    osr_mode_in = '0;
    result_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", 32'({sample_out, sample_out_n}), 32'b01);
    check("rst_ctrl", 32'({enable_loop_out, busy_out, result_valid_out, scan_done_out}), 32'd0);
    check("rst_dac", 32'({dac_p_out, dac_n_out}), 32'd0);
    check("rst_result", 32'({result_data_out, result_ch_out, ch_sel_out}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    kick(4'b0000, 3'd0);
    repeat (5) @(posedge clk);
    #1;
    check("mask0_idle", 32'({busy_out, sample_out, result_valid_out}), 32'd0);

    for (int i = 0; i < 7; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    kick(4'b0001, 3'd0);
    w = 0;
    while (!enable_loop_out && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("conv_first_trial", 32'(dac_p_out), 32'h800);
    check("conv_dac_n", 32'(dac_n_out), 32'h7FF);
    @(posedge clk); #1;
    check("conv_second_trial", 32'(dac_p_out), 32'hC00);
    wait_valid(w);
    hd = result_data_out;
    hc = result_ch_out;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!result_valid_out || result_data_out !== hd || result_ch_out !== hc ||
          enable_loop_out || sample_out) bad = 1'b1;
      if (i == 10) begin
        start_in   = 1'b1;
        ch_mask_in = 4'b1111;
        osr_mode_in = 3'd2;
      end
      if (i == 12) start_in = 1'b0;
    end
    check("stall_stable", 32'(bad), 32'd0);
    check("stall_data", 32'({hc, hd}), 32'({2'd0, 15'hA5C}));
    handshake();
    check("stall_done", 32'({scan_done_out, busy_out, result_valid_out}), 32'b100);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy_out || result_valid_out) bad = 1'b1;
    end
    check("start_while_busy_ignored", 32'(bad), 32'd0);

    kick(4'b0001, 3'd0);
    w = 0;
    while (!enable_loop_out && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midconv_rst_ctrl", 32'({busy_out, enable_loop_out, sample_out, sample_out_n}), 32'b0001);
    check("midconv_rst_dac", 32'({dac_p_out, dac_n_out}), 32'd0);
    rst_n = 1'b1;
    run_scan(vecs[0], "after_rst");

    continuous_in = 1'b1;
    kick(4'b1010, 3'd0);
    mid_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(w);
      chs[k] = result_ch_out;
      if (k == 2) continuous_in = 1'b0;
      handshake();
      if (k < 3 && (scan_done_out || !busy_out)) mid_done = 1'b1;
    end
    check("cont_order", 32'({chs[0], chs[1], chs[2], chs[3]}), 32'b01110111);
    check("cont_no_early_done", 32'(mid_done), 32'd0);
    check("cont_end", 32'({scan_done_out, busy_out}), 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
